// File: rtl/modsqr_iter_ctrl.sv
// modsqr_iter_ctrl: runs one modular-squaring command through the datapath wrapper and returns checkpoint/final results.
// Latency: start toggle SETTLE_CYCLES+1 cycles after accept; a result is valid 1 cycle after msu_valid; every output is registered.
// Backpressure: one-entry result buffer; checkpoints that find it full are dropped (ckpt_overrun), and the final result is held in FLUSH until res_ready.
//
// Ports:
//   clk, reset_n                      host clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_*        command: initial value, squaring count, checkpoint interval (0 = none)
//   abort                             one-cycle cancel of an active run (SETTLE/RUN only)
//   msu_reset, msu_start_toggle       datapath reset (active high) and start kick
//   msu_sq_in                         registered initial value for the datapath
//   msu_valid, msu_sq_out             per-squaring completion pulse and redundant-form result
//   res_valid/res_ready, res_*        result buffer: data, iteration tag, last and error flags
//   busy, ckpt_overrun, timeout_err   status; the two error flags are sticky until the next run starts
module modsqr_iter_ctrl #(
  parameter int MOD_LEN        = 1024,
  parameter int SQ_OUT_BITS    = 1071,
  parameter int ITER_W         = 64,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [MOD_LEN-1:0]     cmd_sq_in,
  input  logic [ITER_W-1:0]      cmd_iters,
  input  logic [ITER_W-1:0]      cmd_ckpt,
  input  logic                   abort,
  output logic                   msu_reset,
  output logic                   msu_start_toggle,
  output logic [MOD_LEN-1:0]     msu_sq_in,
  input  logic                   msu_valid,
  input  logic [SQ_OUT_BITS-1:0] msu_sq_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SQ_OUT_BITS-1:0] res_data,
  output logic [ITER_W-1:0]      res_iter,
  output logic                   res_last,
  output logic                   res_error,
  output logic                   busy,
  output logic                   ckpt_overrun,
  output logic                   timeout_err
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_ONE      = WD_W'(1);
  localparam logic [ITER_W-1:0] ITER_ONE    = ITER_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [SET_W-1:0]       settle_cnt, settle_cnt_nxt;
  logic [WD_W-1:0]        wd_cnt, wd_cnt_nxt;
  logic [ITER_W-1:0]      iters_q, iters_nxt;
  logic [ITER_W-1:0]      ckpt_q, ckpt_nxt;
  logic [ITER_W-1:0]      ckpt_cnt, ckpt_cnt_nxt;
  logic [ITER_W-1:0]      iter_count, iter_count_nxt;
  logic                   toggle_nxt;
  logic [MOD_LEN-1:0]     sq_in_nxt;
  logic                   res_valid_nxt;
  logic [SQ_OUT_BITS-1:0] res_data_nxt;
  logic [ITER_W-1:0]      res_iter_nxt;
  logic                   res_last_nxt;
  logic                   res_error_nxt;
  logic                   overrun_nxt;
  logic                   timeout_nxt;
  logic                   msu_reset_nxt;
  logic                   busy_nxt;
  logic                   cmd_ready_nxt;

  logic                   cmd_acc;
  logic                   res_pend;
  logic [ITER_W-1:0]      iter_inc;

  assign cmd_acc  = cmd_valid & cmd_ready;
  // A result still in the buffer that is not leaving this cycle.
  assign res_pend = res_valid & ~res_ready;
  assign iter_inc = iter_count + ITER_ONE;

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    wd_cnt_nxt     = wd_cnt;
    iters_nxt      = iters_q;
    ckpt_nxt       = ckpt_q;
    ckpt_cnt_nxt   = ckpt_cnt;
    iter_count_nxt = iter_count;
    toggle_nxt     = msu_start_toggle;
    sq_in_nxt      = msu_sq_in;
    res_valid_nxt  = res_pend;
    res_data_nxt   = res_data;
    res_iter_nxt   = res_iter;
    res_last_nxt   = res_last;
    res_error_nxt  = res_error;
    overrun_nxt    = ckpt_overrun;
    timeout_nxt    = timeout_err;

    unique case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          if (cmd_iters == '0) begin
            // Nothing to run: answer immediately with an error result.
            res_valid_nxt = 1'b1;
            res_data_nxt  = '0;
            res_iter_nxt  = '0;
            res_last_nxt  = 1'b1;
            res_error_nxt = 1'b1;
          end else begin
            sq_in_nxt      = cmd_sq_in;
            iters_nxt      = cmd_iters;
            ckpt_nxt       = cmd_ckpt;
            ckpt_cnt_nxt   = cmd_ckpt;
            iter_count_nxt = '0;
            settle_cnt_nxt = '0;
            overrun_nxt    = 1'b0;
            timeout_nxt    = 1'b0;
            state_nxt      = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          toggle_nxt = ~msu_start_toggle;
          wd_cnt_nxt = '0;
          state_nxt  = ST_RUN;
        end else begin
          settle_cnt_nxt = settle_cnt + SET_ONE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Drop any checkpoint still waiting in the buffer.
          state_nxt     = ST_IDLE;
          res_valid_nxt = 1'b0;
        end else if (msu_valid) begin
          iter_count_nxt = iter_inc;
          wd_cnt_nxt     = '0;
          if (iter_inc == iters_q) begin
            // Final result always wins the buffer; a checkpoint it displaces counts as dropped.
            res_valid_nxt = 1'b1;
            res_data_nxt  = msu_sq_out;
            res_iter_nxt  = iter_inc;
            res_last_nxt  = 1'b1;
            res_error_nxt = 1'b0;
            if (res_pend) begin
              overrun_nxt = 1'b1;
            end
            state_nxt = ST_FLUSH;
          end else if (ckpt_q != '0) begin
            if (ckpt_cnt == ITER_ONE) begin
              ckpt_cnt_nxt = ckpt_q;
              if (res_pend) begin
                overrun_nxt = 1'b1;
              end else begin
                res_valid_nxt = 1'b1;
                res_data_nxt  = msu_sq_out;
                res_iter_nxt  = iter_inc;
                res_last_nxt  = 1'b0;
                res_error_nxt = 1'b0;
              end
            end else begin
              ckpt_cnt_nxt = ckpt_cnt - ITER_ONE;
            end
          end
        end else if (wd_cnt == WD_LAST) begin
          // Stalled datapath: report how far it got, as an error result.
          res_valid_nxt = 1'b1;
          res_data_nxt  = '0;
          res_iter_nxt  = iter_count;
          res_last_nxt  = 1'b1;
          res_error_nxt = 1'b1;
          timeout_nxt   = 1'b1;
          if (res_pend) begin
            overrun_nxt = 1'b1;
          end
          state_nxt = ST_FLUSH;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_ONE;
        end
      end

      ST_FLUSH: begin
        if (res_valid & res_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so nothing is combinational from inputs.
    msu_reset_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_FLUSH);
    busy_nxt      = (state_nxt != ST_IDLE);
    cmd_ready_nxt = (state_nxt == ST_IDLE) && !res_valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      wd_cnt           <= '0;
      iters_q          <= '0;
      ckpt_q           <= '0;
      ckpt_cnt         <= '0;
      iter_count       <= '0;
      msu_start_toggle <= 1'b0;
      msu_sq_in        <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      res_iter         <= '0;
      res_last         <= 1'b0;
      res_error        <= 1'b0;
      ckpt_overrun     <= 1'b0;
      timeout_err      <= 1'b0;
      msu_reset        <= 1'b1;
      busy             <= 1'b0;
      cmd_ready        <= 1'b1;
    end else begin
      state            <= state_nxt;
      settle_cnt       <= settle_cnt_nxt;
      wd_cnt           <= wd_cnt_nxt;
      iters_q          <= iters_nxt;
      ckpt_q           <= ckpt_nxt;
      ckpt_cnt         <= ckpt_cnt_nxt;
      iter_count       <= iter_count_nxt;
      msu_start_toggle <= toggle_nxt;
      msu_sq_in        <= sq_in_nxt;
      res_valid        <= res_valid_nxt;
      res_data         <= res_data_nxt;
      res_iter         <= res_iter_nxt;
      res_last         <= res_last_nxt;
      res_error        <= res_error_nxt;
      ckpt_overrun     <= overrun_nxt;
      timeout_err      <= timeout_nxt;
      msu_reset        <= msu_reset_nxt;
      busy             <= busy_nxt;
      cmd_ready        <= cmd_ready_nxt;
    end
  end

endmodule

// File: tb/tb_modsqr_iter_ctrl.sv
// Bench for modsqr_iter_ctrl: directed scenarios plus randomized commands,
// results compared against an expected-result queue built from the command rules,
// and per-cycle status compared against expectations updated by the driver.
module tb_modsqr_iter_ctrl;

  localparam int MOD_LEN        = 32;
  localparam int SQ_OUT_BITS    = 40;
  localparam int ITER_W         = 16;
  localparam int SETTLE_CYCLES  = 16;
  localparam int TIMEOUT_CYCLES = 64;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [MOD_LEN-1:0]     cmd_sq_in;
  logic [ITER_W-1:0]      cmd_iters;
  logic [ITER_W-1:0]      cmd_ckpt;
  logic                   abort;
  logic                   msu_reset;
  logic                   msu_start_toggle;
  logic [MOD_LEN-1:0]     msu_sq_in;
  logic                   msu_valid;
  logic [SQ_OUT_BITS-1:0] msu_sq_out;
  logic                   res_valid;
  logic                   res_ready;
  logic [SQ_OUT_BITS-1:0] res_data;
  logic [ITER_W-1:0]      res_iter;
  logic                   res_last;
  logic                   res_error;
  logic                   busy;
  logic                   ckpt_overrun;
  logic                   timeout_err;

  modsqr_iter_ctrl #(
    .MOD_LEN(MOD_LEN), .SQ_OUT_BITS(SQ_OUT_BITS), .ITER_W(ITER_W),
    .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sq_in(cmd_sq_in),
    .cmd_iters(cmd_iters), .cmd_ckpt(cmd_ckpt), .abort(abort),
    .msu_reset(msu_reset), .msu_start_toggle(msu_start_toggle), .msu_sq_in(msu_sq_in),
    .msu_valid(msu_valid), .msu_sq_out(msu_sq_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_iter(res_iter), .res_last(res_last), .res_error(res_error),
    .busy(busy), .ckpt_overrun(ckpt_overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SQ_OUT_BITS-1:0] data;
    logic [ITER_W-1:0]      iter;
    logic                   last;
    logic                   err;
  } exp_t;

  exp_t                   expq[$];
  logic [ITER_W-1:0]      seen_iter[$];
  logic [SQ_OUT_BITS-1:0] seen_data[$];

  // Status expectations maintained by the driver from the command timeline.
  bit chk_en = 1'b0;
  bit stab_en = 1'b0;
  logic exp_msu_reset, exp_busy, exp_cmd_ready, exp_toggle, exp_ckpt_overrun, exp_timeout_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [SQ_OUT_BITS-1:0] d, input logic [ITER_W-1:0] it,
                          input logic last, input logic err);
    exp_t e;
    e.data = d;
    e.iter = it;
    e.last = last;
    e.err  = err;
    expq.push_back(e);
  endtask

  // Per-cycle status comparison.
  always @(negedge clk) begin
    if (chk_en) begin
      check("msu_reset", 64'(msu_reset), 64'(exp_msu_reset));
      check("busy", 64'(busy), 64'(exp_busy));
      check("cmd_ready", 64'(cmd_ready), 64'(exp_cmd_ready));
      check("msu_start_toggle", 64'(msu_start_toggle), 64'(exp_toggle));
      check("ckpt_overrun", 64'(ckpt_overrun), 64'(exp_ckpt_overrun));
      check("timeout_err", 64'(timeout_err), 64'(exp_timeout_err));
    end
  end

  // Result monitor: every handshake must match the next expected result.
  exp_t mon_e;
  logic p_vld = 1'b0, p_rdy = 1'b0;
  logic [SQ_OUT_BITS-1:0] p_data = '0;
  logic [ITER_W-1:0] p_iter = '0;
  logic p_last = 1'b0;
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got iter %0d last %0d err %0d, required none", res_iter, res_last, res_error);
      end else begin
        mon_e = expq.pop_front();
        check("res_iter", 64'(res_iter), 64'(mon_e.iter));
        check("res_last", 64'(res_last), 64'(mon_e.last));
        check("res_error", 64'(res_error), 64'(mon_e.err));
        if (!mon_e.err) check("res_data", 64'(res_data), 64'(mon_e.data));
        seen_iter.push_back(res_iter);
        seen_data.push_back(res_data);
      end
    end
    if (stab_en && p_vld && !p_rdy) begin
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data", 64'(res_data), 64'(p_data));
      check("hold_iter", 64'(res_iter), 64'(p_iter));
      check("hold_last", 64'(res_last), 64'(p_last));
    end
    p_vld = res_valid; p_rdy = res_ready; p_data = res_data; p_iter = res_iter; p_last = res_last;
  end

  task automatic set_reset_exp();
    exp_msu_reset = 1'b1; exp_busy = 1'b0; exp_cmd_ready = 1'b1; exp_toggle = 1'b0;
    exp_ckpt_overrun = 1'b0; exp_timeout_err = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_msu_reset"}, 64'(msu_reset), 64'd1);
    check({tag, "_toggle"}, 64'(msu_start_toggle), 64'd0);
    check({tag, "_msu_sq_in"}, 64'(msu_sq_in), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(res_data), 64'd0);
    check({tag, "_res_iter"}, 64'(res_iter), 64'd0);
    check({tag, "_res_last"}, 64'(res_last), 64'd0);
    check({tag, "_res_error"}, 64'(res_error), 64'd0);
    check({tag, "_flags"}, 64'({ckpt_overrun, timeout_err}), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_reset_exp();
    check_reset_vals(tag);
  endtask

  task automatic issue(input logic [ITER_W-1:0] iters, input logic [ITER_W-1:0] ckpt,
                       input logic [MOD_LEN-1:0] sq);
    check("cmd_ready_pre", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_iters = iters; cmd_ckpt = ckpt; cmd_sq_in = sq;
    if (iters == '0) push_exp('0, '0, 1'b1, 1'b1);
    tick();
    cmd_valid = 1'b0; cmd_iters = ITER_W'($urandom); cmd_ckpt = ITER_W'($urandom); cmd_sq_in = $urandom;
    exp_cmd_ready = 1'b0;
    if (iters == '0) begin
      check("zero_res_valid", 64'(res_valid), 64'd1);
      if (res_ready) begin
        tick();
        exp_cmd_ready = 1'b1;
      end
    end else begin
      exp_busy = 1'b1; exp_msu_reset = 1'b0; exp_ckpt_overrun = 1'b0; exp_timeout_err = 1'b0;
      check("msu_sq_in", 64'(msu_sq_in), 64'(sq));
    end
  endtask

  task automatic settle();
    repeat (SETTLE_CYCLES) tick();
    exp_toggle = ~exp_toggle;
  endtask

  task automatic pulse(input logic [SQ_OUT_BITS-1:0] d, input bit fin, input bit cap);
    msu_valid = 1'b1;
    msu_sq_out = d;
    tick();
    msu_valid = 1'b0;
    msu_sq_out = {8'($urandom), $urandom};
    if (fin) exp_msu_reset = 1'b1;
    if (cap) check("capture_latency", 64'(res_valid), 64'd1);
    if (fin && res_ready) begin
      tick();
      exp_busy = 1'b0;
      exp_cmd_ready = 1'b1;
    end
  endtask

  // Whole command with res_ready held high: the expected results follow from
  // plain arithmetic -- a checkpoint at each multiple of ckpt, the final at iters.
  task automatic run_cmd(input int iters, input int ckpt, input int maxgap, input bit data_is_k);
    logic [SQ_OUT_BITS-1:0] d;
    bit fin, cap;
    issue(ITER_W'(iters), ITER_W'(ckpt), $urandom);
    settle();
    for (int k = 1; k <= iters; k++) begin
      d = data_is_k ? SQ_OUT_BITS'(k) : {8'($urandom), $urandom};
      fin = (k == iters);
      cap = fin || (ckpt != 0 && (k % ckpt) == 0);
      if (cap) push_exp(d, ITER_W'(k), fin, 1'b0);
      repeat ($urandom_range(maxgap, 0)) tick();
      pulse(d, fin, cap);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_it[4];
    logic [SQ_OUT_BITS-1:0] d;
    int vcyc, delta;
    bit found;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_sq_in = '0; cmd_iters = '0; cmd_ckpt = '0;
    abort = 1'b0; msu_valid = 1'b0; msu_sq_out = '0; res_ready = 1'b1;
    tick();
    apply_reset("rst");
    chk_en = 1'b1;
    tick();

    // Basic: 5 squarings, data = k, one final result.
    seen_iter.delete(); seen_data.delete();
    run_cmd(5, 0, 2, 1'b1);
    check("basic_count", 64'(seen_iter.size()), 64'd1);
    if (seen_iter.size() > 0) begin
      check("basic_iter", 64'(seen_iter[0]), 64'd5);
      check("basic_data", 64'(seen_data[0]), 64'd5);
    end
    tick();

    // Checkpoints every 3 out of 10.
    seen_iter.delete();
    run_cmd(10, 3, 3, 1'b0);
    exp_it = '{3, 6, 9, 10};
    check("ckpt_count", 64'(seen_iter.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen_iter.size(); i++) check("ckpt_iter", 64'(seen_iter[i]), 64'(exp_it[i]));
    check("ckpt_no_overrun", 64'(ckpt_overrun), 64'd0);
    tick();

    // Backpressure: ready low throughout, only the final survives.
    seen_iter.delete();
    res_ready = 1'b0;
    issue(4, 1, $urandom);
    settle();
    for (int k = 1; k <= 4; k++) begin
      d = {8'($urandom), $urandom};
      if (k == 4) push_exp(d, 16'd4, 1'b1, 1'b0);
      tick();
      pulse(d, k == 4, k == 1 || k == 4);
      if (k == 2) exp_ckpt_overrun = 1'b1;
    end
    tick();
    stab_en = 1'b1;
    repeat (5) tick();
    check("bp_iter", 64'(res_iter), 64'd4);
    check("bp_last", 64'(res_last), 64'd1);
    check("bp_overrun", 64'(ckpt_overrun), 64'd1);
    stab_en = 1'b0;
    res_ready = 1'b1;
    tick();
    exp_busy = 1'b0; exp_cmd_ready = 1'b1;
    check("bp_count", 64'(seen_iter.size()), 64'd1);
    tick();

    // Abort with a checkpoint pending in the buffer.
    res_ready = 1'b0;
    issue(10, 2, $urandom);
    settle();
    pulse({8'($urandom), $urandom}, 1'b0, 1'b0);
    tick();
    pulse({8'($urandom), $urandom}, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_busy = 1'b0; exp_msu_reset = 1'b1; exp_cmd_ready = 1'b1;
    check("abort_drop", 64'(res_valid), 64'd0);
    res_ready = 1'b1;
    // msu_valid while idle must not produce anything.
    msu_valid = 1'b1;
    repeat (2) tick();
    msu_valid = 1'b0;
    tick();
    check("idle_valid_ignored", 64'(res_valid), 64'd0);

    // Zero-iteration command: immediate error result, no toggle flip.
    seen_iter.delete();
    issue(0, 0, $urandom);
    check("zero_count", 64'(seen_iter.size()), 64'd1);
    if (seen_iter.size() > 0) check("zero_iter", 64'(seen_iter[0]), 64'd0);
    tick();

    // Watchdog: one valid out of three.
    issue(3, 0, $urandom);
    settle();
    repeat (2) tick();
    pulse({8'($urandom), $urandom}, 1'b0, 1'b0);
    vcyc = cyc;
    push_exp('0, 16'd1, 1'b1, 1'b1);
    chk_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < TIMEOUT_CYCLES + 8; i++) begin
      if (res_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("timeout_seen", 64'(found), 64'd1);
    if (found) begin
      delta = cyc - vcyc;
      check("timeout_delay_in_window", 64'(delta >= TIMEOUT_CYCLES - 1 && delta <= TIMEOUT_CYCLES + 1), 64'd1);
      check("timeout_msu_reset", 64'(msu_reset), 64'd1);
      check("timeout_flag", 64'(timeout_err), 64'd1);
      exp_msu_reset = 1'b1; exp_timeout_err = 1'b1;
      chk_en = 1'b1;
      tick();
      exp_busy = 1'b0; exp_cmd_ready = 1'b1;
    end else begin
      apply_reset("recover");
      chk_en = 1'b1;
    end
    tick();

    // Reset pulse in the middle of a run, then a normal command.
    issue(6, 0, $urandom);
    settle();
    pulse({8'($urandom), $urandom}, 1'b0, 1'b0);
    pulse({8'($urandom), $urandom}, 1'b0, 1'b0);
    apply_reset("midrst");
    tick();
    run_cmd(3, 1, 1, 1'b0);
    tick();

    // Randomized commands.
    for (int n = 0; n < 10; n++) begin
      run_cmd(int'($urandom_range(12, 1)), int'($urandom_range(4, 0)), 4, 1'b0);
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (3) tick();
    check("expected_queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modsqr_iter_ctrl.md
# modsqr_iter_ctrl

Iteration sequencer for the modular-squaring datapath wrapper. Accepts a command (initial value, iteration count, checkpoint interval), releases the datapath from reset, kicks it with a start toggle, and counts its per-squaring valid pulses. It captures checkpoint and final results into a one-entry output buffer with a valid/ready handshake, then halts the datapath. A watchdog flags a stalled datapath. It sits in the host `clk` domain between the host command/result queues and the squaring wrapper.

## Interface
- MOD_LEN, 1024, width of initial value
- SQ_OUT_BITS, 1071, width of redundant-form datapath output (21 x 51)
- ITER_W, 64, iteration counter width
- SETTLE_CYCLES, 16, clk cycles between datapath reset release and start toggle
- TIMEOUT_CYCLES, 4096, max clk cycles allowed between start/valid events

- clk  in  1  host clock; sole clock of this block
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_sq_in  in  MOD_LEN  initial value
- cmd_iters  in  ITER_W  squarings to perform
- cmd_ckpt  in  ITER_W  checkpoint interval; 0 = none
- abort  in  1  one-cycle abort request
- msu_reset  out  1  datapath reset, active-high
- msu_start_toggle  out  1  toggles once per kick
- msu_sq_in  out  MOD_LEN  registered initial value
- msu_valid  in  1  one-cycle pulse per completed squaring (already in clk domain)
- msu_sq_out  in  SQ_OUT_BITS  datapath result, stable while msu_valid high
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_data  out  SQ_OUT_BITS  captured result
- res_iter  out  ITER_W  iteration number of res_data
- res_last  out  1  final result of the command
- res_error  out  1  result carries no data (bad command or timeout)
- busy  out  1  state != IDLE
- ckpt_overrun  out  1  sticky; a checkpoint was dropped
- timeout_err  out  1  sticky; watchdog fired

## Operation
- States: IDLE, SETTLE, RUN, FLUSH.
- IDLE: msu_reset=1. cmd_ready = !res_valid. On accept:
  - cmd_iters==0: load res_error=1, res_last=1, res_iter=0, and stay in IDLE.
  - Otherwise: register msu_sq_in, iters and ckpt, clear iter_count, ckpt_overrun and timeout_err, and go to SETTLE.
- SETTLE: msu_reset=0. Count SETTLE_CYCLES. On the last cycle flip msu_start_toggle, clear the watchdog, and go to RUN.
- RUN behaviour on msu_valid:
  - iter_count increments by 1 and the watchdog clears.
  - If the new count == iters: capture msu_sq_out, res_last=1, res_iter=count, and go to FLUSH.
  - Else if ckpt!=0 and count hits the checkpoint counter: capture with res_last=0. If res_valid is still pending, leave the buffer unchanged and set ckpt_overrun.
  - The checkpoint counter is a down-counter reloaded with ckpt. Multiplication and division are not used.
- Final vs pending checkpoint: a final capture always overwrites a pending checkpoint; that case also sets ckpt_overrun.
- FLUSH: msu_reset=1. Wait for res_valid&res_ready, then go to IDLE.
- Watchdog: in SETTLE-exit/RUN, if the watchdog reaches TIMEOUT_CYCLES with no msu_valid, load res_error=1, res_last=1, res_iter=iter_count, set timeout_err, and go to FLUSH.
- abort in SETTLE or RUN: go to IDLE with msu_reset=1, produce no result, and discard any pending checkpoint. abort in IDLE or FLUSH is ignored.
- msu_valid outside RUN is ignored.
- Counters are ITER_W wide. iter_count cannot wrap because the match at iters stops the run.

## Timing
- Reset values:
  - state=IDLE, msu_reset=1, msu_start_toggle=0, msu_sq_in=0.
  - res_valid=0, res_data=0, res_iter=0, res_last=0, res_error=0.
  - ckpt_overrun=0, timeout_err=0, busy=0, cmd_ready=1.
- Accept at cycle T: busy=1 and msu_reset=0 at T+1. msu_start_toggle flips at T+1+SETTLE_CYCLES.
- Capture: msu_valid at cycle V gives res_valid=1 with data at V+1.
- Final capture: msu_reset=1 from V+1.
- res_valid holds with all res_* stable until accepted. It drops the cycle after the handshake unless a new capture lands in the same cycle, in which case the new data is valid at the next cycle.
- FLUSH handshake at cycle H: IDLE, with cmd_ready=1 at H+1.
- cmd_ready is registered. There is no combinational path from any input to any output.
- reset_n low mid-run: reset values apply the next cycle. msu_reset returns to 1 immediately, and the pending result is lost.

## Test plan
- Basic: cmd_iters=5, cmd_ckpt=0, res_ready=1, msu_valid pulsed 5 times with msu_sq_out=k -> exactly one result, res_data=5, res_iter=5, res_last=1. msu_reset is 0 from T+1 to the 5th valid+1, and the toggle flips once at T+17.
- Checkpoints: cmd_iters=10, cmd_ckpt=3 -> results at iter 3, 6, 9 with res_last=0, then iter 10 with res_last=1; ckpt_overrun=0.
- Backpressure: cmd_ckpt=1, res_ready=0 for the whole run with cmd_iters=4 -> ckpt_overrun=1; the single result is iter 4, res_last=1. FLUSH is held until res_ready=1.
- Timeout: cmd_iters=3, only 1 msu_valid, TIMEOUT_CYCLES=64 -> res_error=1, res_iter=1, timeout_err=1; msu_reset=1 within 1 cycle of expiry.
- Abort/zero: abort after 2 valids -> IDLE, no result, msu_reset=1 next cycle. A following cmd_iters=0 -> res_error=1, res_iter=0, with no toggle flip.
- Reset mid-run: reset_n low for 1 cycle during RUN -> all outputs at reset values next cycle, and the next command runs normally.
